// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic calc_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO buffering core-side writes for the transmitter.
// A push while full is dropped even if a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes serialized as 8N1/8E1/8N2/8E2, LSB first.
// tx_o is registered from the current state, so the line trails the state by one
// clock; every bit still lasts div+1 clocks and frames are separated by one idle clock.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        cfg_en_i,
  input  logic [DIV_W-1:0]            cfg_div_i,
  input  logic                        cfg_parity_en_i,
  input  logic                        cfg_stop2_i,
  input  logic [7:0]                  tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  uart_tx_state_e   state_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx_q;
  logic [DIV_W-1:0] baud_q;
  logic [DIV_W-1:0] div_q;
  logic             par_en_q;
  logic             stop2_q;
  logic             par_q;
  logic             stop_second_q;
  logic             tx_q;

  logic [7:0]       fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             bit_done;

  assign pop      = (state_q == IDLE) && cfg_en_i && !fifo_empty;
  assign bit_done = (baud_q == '0);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_valid_i),
    .data_i  (tx_data_i),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign tx_ready_o = !fifo_full;
  assign busy_o     = (state_q != IDLE) || !fifo_empty;
  assign tx_o       = tx_q;

  // Frame sequencer: latches byte and config at pop, then walks start/data/parity/stop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_idx_q     <= '0;
      baud_q        <= '0;
      div_q         <= '0;
      par_en_q      <= 1'b0;
      stop2_q       <= 1'b0;
      par_q         <= 1'b0;
      stop_second_q <= 1'b0;
      tx_q          <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q       <= fifo_data;
            par_q         <= calc_parity(fifo_data);
            div_q         <= cfg_div_i;
            baud_q        <= cfg_div_i;
            par_en_q      <= cfg_parity_en_i;
            stop2_q       <= cfg_stop2_i;
            bit_idx_q     <= '0;
            stop_second_q <= 1'b0;
            state_q       <= START;
          end
        end
        START: begin
          tx_q   <= 1'b0;
          baud_q <= bit_done ? div_q : baud_q - 1'b1;
          if (bit_done) state_q <= DATA;
        end
        DATA: begin
          tx_q   <= shift_q[0];
          baud_q <= bit_done ? div_q : baud_q - 1'b1;
          if (bit_done) begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
              state_q <= par_en_q ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          tx_q   <= par_q;
          baud_q <= bit_done ? div_q : baud_q - 1'b1;
          if (bit_done) state_q <= STOP;
        end
        STOP: begin
          tx_q   <= 1'b1;
          baud_q <= bit_done ? div_q : baud_q - 1'b1;
          if (bit_done) begin
            if (stop2_q && !stop_second_q) begin
              stop_second_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus enqueues expected frames, a line monitor
// decodes tx_o and checks every clock of every bit against the queued frame.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en;
  logic [15:0] cfg_div;
  logic        cfg_pe;
  logic        cfg_s2;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx;
  logic        busy;
  logic [3:0]  fcount;

  uart_tx #(
    .FIFO_DEPTH (8),
    .DIV_W      (16)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .cfg_en_i        (cfg_en),
    .cfg_div_i       (cfg_div),
    .cfg_parity_en_i (cfg_pe),
    .cfg_stop2_i     (cfg_s2),
    .tx_data_i       (tx_data),
    .tx_valid_i      (tx_valid),
    .tx_ready_o      (tx_ready),
    .tx_o            (tx),
    .busy_o          (busy),
    .fifo_count_o    (fcount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    int         div;
    bit         pe;
    bit         s2;
    bit         b2b;
  } exp_t;

  exp_t sbq[$];
  bit   mon_busy  = 1'b0;
  bit   mon_abort = 1'b0;

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  // Checks tx_o on each of nclk consecutive negedges; first=1 means the current
  // negedge is already the first sample.
  task automatic mon_bit(input logic expv, input int nclk, input string nm, input bit first);
    bit   bad = 1'b0;
    logic got = expv;
    for (int i = 0; i < nclk; i++) begin
      if (!(first && i == 0)) @(negedge clk);
      if (!rst_n) begin
        mon_abort = 1'b1;
        return;
      end
      if (tx !== expv) begin
        bad = 1'b1;
        got = tx;
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: tx_o=%b expected %b", nm, got, expv);
    end
  endtask

  // Line monitor: detect start bit, pop expected frame, check every bit.
  initial begin : monitor
    exp_t e;
    int   idle;
    idle = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || tx !== 1'b0) begin
        if (tx === 1'b1) idle++;
      end else begin
        mon_busy  = 1'b1;
        mon_abort = 1'b0;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: start bit seen with empty scoreboard");
        end else begin
          e = sbq.pop_front();
          if (e.b2b) chk("interframe_gap", idle, 1);
          mon_bit(1'b0, e.div + 1, $sformatf("start_of_%02h", e.d), 1'b1);
          for (int i = 0; i < 8 && !mon_abort; i++)
            mon_bit(e.d[i], e.div + 1, $sformatf("data%0d_of_%02h", i, e.d), 1'b0);
          if (e.pe && !mon_abort)
            mon_bit(^e.d, e.div + 1, $sformatf("parity_of_%02h", e.d), 1'b0);
          if (!mon_abort)
            mon_bit(1'b1, (e.div + 1) * (e.s2 ? 2 : 1), $sformatf("stop_of_%02h", e.d), 1'b0);
        end
        idle     = 0;
        mon_busy = 1'b0;
      end
    end
  end

  task automatic enq(input logic [7:0] d, input int dv, input bit b2b);
    exp_t e;
    e.d   = d;
    e.div = dv;
    e.pe  = cfg_pe;
    e.s2  = cfg_s2;
    e.b2b = b2b;
    sbq.push_back(e);
  endtask

  // One-cycle valid pulse; returns 1ns after the sampling edge.
  task automatic push(input logic [7:0] d, input bit sb, input bit b2b, input int dv);
    bit acc;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    acc      = tx_ready;
    @(posedge clk);
    if (acc && sb) enq(d, dv, b2b);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int n = 0;
    while ((sbq.size() != 0 || mon_busy || busy) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(n >= maxc), 0);
    repeat (2) @(negedge clk);
  endtask

  int acc_cyc;
  int n;

  initial begin
    rst_n    = 1'b0;
    cfg_en   = 1'b0;
    cfg_div  = 16'd3;
    cfg_pe   = 1'b0;
    cfg_s2   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_count", fcount, 0);
    rst_n  = 1'b1;
    cfg_en = 1'b1;

    // 8N1, div=3: latency and frame length
    push(8'h55, 1'b1, 1'b0, 3);
    acc_cyc = cyc;
    @(negedge clk);
    chk("lat_edge0_tx", tx, 1);
    chk("count_after_push", fcount, 1);
    chk("busy_after_push", busy, 1);
    @(negedge clk);
    chk("lat_edge1_tx", tx, 1);
    @(negedge clk);
    chk("lat_edge2_tx", tx, 0);
    while (busy && (cyc - acc_cyc) < 200) @(negedge clk);
    // one pop cycle plus a 40-clock frame
    chk("busy_fall_cycles", cyc - acc_cyc, 41);
    wait_idle(500, "idle_t1");

    // 8E1: 0xA7 parity 1, 0x03 parity 0; second push coincides with first pop
    cfg_pe = 1'b1;
    push(8'hA7, 1'b1, 1'b0, 3);
    push(8'h03, 1'b1, 1'b1, 3);
    @(negedge clk);
    chk("push_pop_same_cycle_count", fcount, 1);
    wait_idle(500, "idle_t2");

    // FIFO fill while disabled, then drain back-to-back
    cfg_pe = 1'b0;
    cfg_en = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i), 1'b1, i != 0, 3);
    @(negedge clk);
    chk("full_ready", tx_ready, 0);
    chk("full_count", fcount, 8);
    chk("full_busy", busy, 1);
    tx_data  = 8'h18;
    tx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_off_count", fcount, 8);
    chk("disabled_tx", tx, 1);
    tx_valid = 1'b0;
    cfg_en   = 1'b1;
    wait_idle(1000, "idle_t3");

    // 8N2 div=1, then a divider change mid-frame applies to the next frame only
    cfg_s2  = 1'b1;
    cfg_div = 16'd1;
    push(8'hFF, 1'b1, 1'b0, 1);
    push(8'h81, 1'b1, 1'b1, 7);
    repeat (3) @(negedge clk);
    cfg_div = 16'd7;
    wait_idle(1000, "idle_t4");

    // Reset during data bit 4 of 0xA5 (bit4 = 0) with a second byte queued
    cfg_s2  = 1'b0;
    cfg_div = 16'd3;
    push(8'hA5, 1'b1, 1'b0, 3);
    push(8'h11, 1'b0, 1'b0, 3);
    repeat (22) @(posedge clk);
    #1;
    chk("pre_reset_tx_bit4", tx, 0);
    chk("pre_reset_count", fcount, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_tx", tx, 1);
    chk("midreset_count", fcount, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", tx_ready, 1);
    rst_n = 1'b1;
    push(8'h3C, 1'b1, 1'b0, 3);
    wait_idle(500, "idle_t5");

    // Enable dropped mid-frame: frame finishes, queued byte stays until re-enabled
    cfg_div = 16'd1;
    push(8'h5A, 1'b1, 1'b0, 1);
    push(8'hC3, 1'b0, 1'b0, 1);
    repeat (2) @(negedge clk);
    cfg_en = 1'b0;
    n = 0;
    while ((sbq.size() != 0 || mon_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("en_low_count", fcount, 1);
    chk("en_low_busy", busy, 1);
    chk("en_low_tx", tx, 1);
    enq(8'hC3, 1, 1'b0);
    cfg_en = 1'b1;
    wait_idle(500, "idle_t7");

    // "Hi\n" at div=867
    cfg_div = 16'd867;
    push(8'h48, 1'b1, 1'b0, 867);
    push(8'h69, 1'b1, 1'b1, 867);
    push(8'h0A, 1'b1, 1'b1, 867);
    wait_idle(40000, "idle_t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Synthesizable UART transmitter that drives the serial line consumed by the simulation UART bus monitor, i.e. the `rx` input of the testbench interface. Bytes are taken from a core-side valid/ready stream and buffered in a small FIFO. Each byte is serialized 8N1/8E1/8N2/8E2, LSB first, with a programmable baud divider. It sits between the peripheral register interface and the chip `uart_tx` pad.

Parameters:
FIFO_DEPTH, 8, number of byte entries in the TX FIFO; power of two, ≥2.
DIV_W, 16, width of the baud divider field.

Ports:
clk_i  input  1  system clock
rst_ni  input  1  synchronous, active-low reset
cfg_en_i  input  1  transmitter enable; frames start only while high
cfg_div_i  input  DIV_W  clocks per bit minus 1
cfg_parity_en_i  input  1  append even parity bit
cfg_stop2_i  input  1  two stop bits when high
tx_data_i  input  8  byte to send
tx_valid_i  input  1  byte valid
tx_ready_o  output  1  FIFO can accept (= not full)
tx_o  output  1  serial line, idle high
busy_o  output  1  frame in progress or FIFO non-empty
fifo_count_o  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered

Behaviour:
- Reset on rising clk_i with rst_ni=0:
  - tx_o=1, tx_ready_o=1, busy_o=0, fifo_count_o=0.
  - FSM returns to IDLE; FIFO is flushed.
  - Mid-frame reset aborts the frame; tx_o is 1 after that edge.
- Push: tx_valid_i && tx_ready_o on an edge writes one entry. When full, tx_ready_o=0 and the input is held off. There is no write-through when full, even if a pop happens in the same cycle.
- Simultaneous push and pop when not full: count is unchanged and data order is preserved.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if cfg_en_i && FIFO non-empty, pop the head and latch the byte, cfg_div_i, cfg_parity_en_i and cfg_stop2_i. Go to START; tx_o=0 from the next cycle.
  - START: hold 0 for one bit time, then go to DATA.
  - DATA: send bits 0..7, LSB first, one bit time each, using a 3-bit bit index.
  - After DATA: go to PARITY if parity is enabled, else STOP.
  - PARITY: send ^data (even parity, so the 9 bits have an even count of ones).
  - STOP: tx_o=1 for 1 or 2 bit times, then return to IDLE.
- Back-to-back: if the FIFO is non-empty when STOP ends, IDLE pops in the next cycle. This adds exactly one extra idle-high cycle between frames.
- Bit time: a down-counter loaded with the latched div, decrementing each clock; the bit ends at 0. Each bit lasts div+1 clocks; div=0 gives 1 clock per bit with no underflow. Frame length = (div+1)*(10 + parity + stop2) clocks.
- Latency: a push into an empty FIFO while IDLE and enabled drives tx_o low two edges after the accepting edge.
- Config changes mid-frame have no effect until the next frame, because config is latched at pop.
- cfg_en_i falling mid-frame: the current frame completes and no further pops occur.
- busy_o = (state != IDLE) || (fifo_count_o != 0). It is registered-consistent with the state and count.
- All outputs come directly from registers; tx_o has no combinational path from the inputs.

Decomposition:
- Package uart_pkg:
  - state enum uart_tx_state_e.
  - function calc_parity(logic [7:0]) returning ^d.
  - localparam UART_DATA_BITS=8.
- Sub-module uart_tx_fifo: synchronous FIFO with DEPTH and WIDTH=8, ports push/pop/full/empty/count, and the same clk_i/rst_ni.
- The FSM, baud counter and shifter stay in uart_tx.

Test Plan:
1. div=3, parity off, stop1; push 0x55 → tx_o low 2 edges after accept; bit pattern 0,1,0,1,0,1,0,1,0,1 with 4 clocks per bit; busy_o falls after 40 clocks of frame.
2. div=3, parity on; push 0xA7 (five ones) → parity bit 1; push 0x03 → parity bit 0; frame is 44 clocks.
3. FIFO fill: disable cfg_en_i, push 8 bytes 0x10..0x17 → tx_ready_o=0 and count=8; a 9th valid is held; enable → bytes appear in order, frames separated by exactly 1 idle clock.
4. stop2=1, div=1; push 0xFF → stop high for 4 clocks before the next start; change cfg_div_i to 7 mid-frame → current frame unaffected, next frame uses 8 clocks per bit.
5. Reset asserted during DATA bit 4 → next edge tx_o=1, count=0, busy_o=0; a subsequent push of 0x3C transmits correctly.
6. Integration: clk 100 MHz, div=867 (115207 baud); send "Hi\n" through the UART bus monitor rx → monitor prints "RX string: Hi".
